// File: rtl/fifo2axis.sv
// Pops wide words from a FIFO (one outstanding read) and streams each word as
// N narrow AXI-Stream beats, MS slice first, with frame TLAST/USER markers.
module fifo2axis #(
  parameter int FAW             = 8,
  parameter int AXIS_DATA_WIDTH = 32,
  parameter int AXI4_DATA_WIDTH = 128,
  parameter int PKT_BEATS       = 16
) (
  input  logic                         M_AXIS_ACLK,
  input  logic                         M_AXIS_ARESET,
  output logic                         frd_rdy,
  input  logic                         frd_vld,
  input  logic [AXI4_DATA_WIDTH-1:0]   frd_dat,
  input  logic                         frd_empty,
  input  logic [FAW:0]                 frd_cnt,
  output logic                         M_AXIS_TVALID,
  output logic [AXIS_DATA_WIDTH-1:0]   M_AXIS_TDATA,
  output logic [AXIS_DATA_WIDTH/8-1:0] M_AXIS_TSTRB,
  output logic                         M_AXIS_TLAST,
  output logic                         M_AXIS_USER,
  input  logic                         M_AXIS_TREADY
);
  localparam int N  = AXI4_DATA_WIDTH / AXIS_DATA_WIDTH;
  localparam int SW = $clog2(N);
  localparam int FW = $clog2(PKT_BEATS) + 1;

  typedef enum logic [1:0] {IDLE, RD, WT, TX} state_t;

  state_t                                  r_state, w_next;
  logic [AXI4_DATA_WIDTH-1:0]              r_buf;
  logic [SW-1:0]                           r_slice;
  logic [FW-1:0]                           r_frame;
  logic [N-1:0][AXIS_DATA_WIDTH-1:0]       w_slices;
  logic [SW-1:0]                           w_idx;
  logic                                    w_xfer;
  logic                                    w_last_slice;
  logic                                    w_unused_cnt;

  // Occupancy is informational only.
  assign w_unused_cnt = ^frd_cnt;

  assign w_slices     = r_buf;
  assign w_idx        = SW'(N - 1) - r_slice;
  assign w_last_slice = (r_slice == SW'(N - 1));
  assign w_xfer       = M_AXIS_TVALID & M_AXIS_TREADY;

  always_comb begin
    w_next        = r_state;
    frd_rdy       = 1'b0;
    M_AXIS_TVALID = 1'b0;
    M_AXIS_TDATA  = '0;
    M_AXIS_TSTRB  = '0;
    M_AXIS_TLAST  = 1'b0;
    M_AXIS_USER   = 1'b0;
    case (r_state)
      IDLE: if (!frd_empty) w_next = RD;
      RD: begin
        frd_rdy = 1'b1;
        w_next  = WT;
      end
      WT: if (frd_vld) w_next = TX;
      TX: begin
        M_AXIS_TVALID = 1'b1;
        M_AXIS_TDATA  = w_slices[w_idx];
        M_AXIS_TSTRB  = '1;
        M_AXIS_TLAST  = (r_frame == FW'(PKT_BEATS - 1));
        M_AXIS_USER   = (r_frame == '0);
        if (M_AXIS_TREADY && w_last_slice) w_next = frd_empty ? IDLE : RD;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge M_AXIS_ACLK or posedge M_AXIS_ARESET) begin
    if (M_AXIS_ARESET) begin
      r_state <= IDLE;
      r_buf   <= '0;
      r_slice <= '0;
      r_frame <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == WT && frd_vld) begin
        r_buf   <= frd_dat;
        r_slice <= '0;
      end else if (w_xfer) begin
        r_slice <= w_last_slice ? '0 : r_slice + SW'(1);
      end
      // Frame position runs across word boundaries.
      if (w_xfer) r_frame <= (r_frame == FW'(PKT_BEATS - 1)) ? '0 : r_frame + FW'(1);
    end
  end
endmodule

// File: tb/tb_fifo2axis.sv
// Directed bench: a FIFO model with programmable read latency feeds two DUTs
// (PKT_BEATS=8 and PKT_BEATS=1) in lockstep; beats are collected and checked.
module tb_fifo2axis;
  localparam int AW = 128, DW = 32, FAW = 8;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            frd_vld = 1'b0;
  logic [AW-1:0]   frd_dat = '0;
  logic            frd_empty = 1'b1;
  logic [FAW:0]    frd_cnt = '0;
  logic            tready = 1'b1;

  logic            rdy0, tvalid0, tlast0, user0;
  logic [DW-1:0]   tdata0;
  logic [DW/8-1:0] tstrb0;
  logic            rdy1, tvalid1, tlast1, user1;
  logic [DW-1:0]   tdata1;
  logic [DW/8-1:0] tstrb1;

  fifo2axis #(.FAW(FAW), .AXIS_DATA_WIDTH(DW), .AXI4_DATA_WIDTH(AW), .PKT_BEATS(8)) dut0 (
    .M_AXIS_ACLK(clk), .M_AXIS_ARESET(rst), .frd_rdy(rdy0), .frd_vld(frd_vld),
    .frd_dat(frd_dat), .frd_empty(frd_empty), .frd_cnt(frd_cnt),
    .M_AXIS_TVALID(tvalid0), .M_AXIS_TDATA(tdata0), .M_AXIS_TSTRB(tstrb0),
    .M_AXIS_TLAST(tlast0), .M_AXIS_USER(user0), .M_AXIS_TREADY(tready));

  fifo2axis #(.FAW(FAW), .AXIS_DATA_WIDTH(DW), .AXI4_DATA_WIDTH(AW), .PKT_BEATS(1)) dut1 (
    .M_AXIS_ACLK(clk), .M_AXIS_ARESET(rst), .frd_rdy(rdy1), .frd_vld(frd_vld),
    .frd_dat(frd_dat), .frd_empty(frd_empty), .frd_cnt(frd_cnt),
    .M_AXIS_TVALID(tvalid1), .M_AXIS_TDATA(tdata1), .M_AXIS_TSTRB(tstrb1),
    .M_AXIS_TLAST(tlast1), .M_AXIS_USER(user1), .M_AXIS_TREADY(tready));

  always #5 clk = ~clk;

  localparam logic [AW-1:0] W1 = 128'h00112233_44556677_8899AABB_CCDDEEFF;
  localparam logic [AW-1:0] W2 = 128'hDEADBEEF_CAFEF00D_12345678_9ABCDEF0;

  int nchk = 0, nerr = 0;

  task automatic chk(input string tag, input logic [127:0] act, input logic [127:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // FIFO model: frd_vld returns lat cycles after the frd_rdy cycle.
  logic [AW-1:0] fq[$];
  logic [AW-1:0] pword;
  int            lat = 1;
  int            pend = 0;

  always @(negedge clk) begin
    frd_vld = 1'b0;
    if (rst) pend = 0;
    else begin
      if (pend > 0) begin
        pend--;
        if (pend == 0) begin
          frd_vld = 1'b1;
          frd_dat = pword;
        end
      end
      if (rdy0 && fq.size() > 0) begin
        pword = fq.pop_front();
        pend  = lat;
      end
    end
    frd_empty = (fq.size() == 0);
    frd_cnt   = (FAW+1)'(fq.size());
  end

  // Monitor: collect transfers, frd_rdy pulses, TVALID gaps, stall stability.
  typedef struct {
    logic [DW-1:0]   d;
    logic [DW/8-1:0] s;
    logic            l, u, l1, u1;
  } beat_t;
  beat_t bq[$];
  int    cyc = 0, rdy_cnt = 0, rdy_cyc = 0, first_v = -1, gap = 0, last_gap = -1;
  logic  seen = 1'b0, pstall = 1'b0;
  logic [DW+1:0] pd;

  always @(negedge clk) begin
    cyc++;
    if (!rst) begin
      if (rdy0) begin
        rdy_cnt++;
        rdy_cyc = cyc;
      end
      if (tvalid0 && first_v < 0) first_v = cyc;
      if (pstall) chk("stall_hold", {tdata0, tlast0, user0}, pd);
      if (tvalid0 && tready) bq.push_back('{tdata0, tstrb0, tlast0, user0, tlast1, user1});
      if (tvalid0) begin
        if (seen && gap > 0) last_gap = gap;
        gap  = 0;
        seen = 1'b1;
      end else gap++;
      pstall = tvalid0 && !tready;
      pd     = {tdata0, tlast0, user0};
    end
  end

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    fq.delete();
    lat = 1;
    tready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    bq.delete();
    rdy_cnt = 0; first_v = -1; gap = 0; last_gap = -1; seen = 1'b0; pstall = 1'b0;
    rst = 1'b0;
  endtask

  task automatic wait_beats(input int n);
    int i;
    for (i = 0; i < 200; i++) begin
      if (bq.size() >= n) break;
      @(posedge clk);
    end
    if (i == 200) chk("beat_timeout", bq.size(), n);
  endtask

  task automatic chk_word(input string tag, input int base, input logic [AW-1:0] w);
    for (int k = 0; k < 4; k++) begin
      logic [AW-1:0] t;
      t = w >> (96 - 32*k);
      if (base + k < bq.size()) chk(tag, bq[base+k].d, t[DW-1:0]);
      else chk({tag, "_missing"}, base + k, bq.size());
    end
  endtask

  initial begin
    logic [7:0] lv, uv;
    logic [3:0] sv;
    #200000;
    $display("FAIL watchdog: simulation did not finish, required finish before 200000");
    $fatal(1);
  end

  initial begin
    logic [7:0] lv, uv;
    int i;

    // Single word, 1-cycle latency, then back to IDLE.
    do_reset();
    chk("rst_rdy", rdy0, 0);
    chk("rst_tvalid", tvalid0, 0);
    chk("rst_tdata", tdata0, 0);
    chk("rst_tstrb", tstrb0, 0);
    chk("rst_tlast", tlast0, 0);
    chk("rst_user", user0, 0);
    fq.push_back(W1);
    wait_beats(4);
    repeat (6) @(posedge clk);
    #1;
    chk_word("t1_data", 0, W1);
    lv = '0; uv = '0;
    for (int k = 0; k < 4 && k < bq.size(); k++) begin
      lv[k] = bq[k].l; uv[k] = bq[k].u;
      chk("t1_tstrb", bq[k].s, 4'hF);
    end
    chk("t1_tlast", lv, 8'h00);
    chk("t1_user", uv, 8'h01);
    chk("t1_rdy_cnt", rdy_cnt, 1);
    chk("t1_latency", first_v - rdy_cyc, 2);
    chk("t1_idle_tvalid", tvalid0, 0);
    chk("t1_idle_tdata", tdata0, 0);
    chk("t1_nbeats", bq.size(), 4);

    // Two queued words: one 8-beat frame, 2-cycle TVALID gap.
    do_reset();
    fq.push_back(W1);
    fq.push_back(W2);
    wait_beats(8);
    repeat (6) @(posedge clk);
    #1;
    chk_word("t2_data_w1", 0, W1);
    chk_word("t2_data_w2", 4, W2);
    lv = '0; uv = '0;
    for (int k = 0; k < 8 && k < bq.size(); k++) begin
      lv[k] = bq[k].l; uv[k] = bq[k].u;
    end
    chk("t2_tlast", lv, 8'h80);
    chk("t2_user", uv, 8'h01);
    chk("t2_rdy_cnt", rdy_cnt, 2);
    chk("t2_gap", last_gap, 2);
    chk("t2_nbeats", bq.size(), 8);

    // Backpressure 1,0,0,1 while streaming.
    do_reset();
    fq.push_back(W2);
    for (i = 0; i < 50 && !tvalid0; i++) begin
      @(posedge clk); #1;
    end
    chk("t3_tvalid_seen", tvalid0, 1);
    tready = 1'b1;
    @(posedge clk); #1; tready = 1'b0;
    @(posedge clk); #1; tready = 1'b0;
    @(posedge clk); #1; tready = 1'b1;
    wait_beats(4);
    repeat (6) @(posedge clk);
    #1;
    chk_word("t3_data", 0, W2);
    chk("t3_nbeats", bq.size(), 4);

    // 3-cycle FIFO latency.
    do_reset();
    lat = 3;
    fq.push_back(W2);
    wait_beats(4);
    repeat (6) @(posedge clk);
    #1;
    chk("t4_latency", first_v - rdy_cyc, 4);
    chk("t4_rdy_cnt", rdy_cnt, 1);
    chk_word("t4_data", 0, W2);

    // Reset during the third beat, then refill.
    do_reset();
    fq.push_back(W1);
    wait_beats(2);
    #2;
    chk("t5_beat3", tdata0, 32'h8899AABB);
    rst = 1'b1;
    #1;
    chk("t5_rst_tvalid", tvalid0, 0);
    chk("t5_rst_tdata", tdata0, 0);
    chk("t5_rst_tstrb", tstrb0, 0);
    chk("t5_rst_tlast", tlast0, 0);
    chk("t5_rst_user", user0, 0);
    chk("t5_rst_rdy", rdy0, 0);
    fq.delete();
    repeat (2) @(posedge clk);
    #1;
    bq.delete();
    rdy_cnt = 0; first_v = -1; pstall = 1'b0;
    rst = 1'b0;
    fq.push_back(W2);
    wait_beats(4);
    repeat (4) @(posedge clk);
    #1;
    chk_word("t5_data", 0, W2);
    uv = '0; lv = '0;
    for (int k = 0; k < 4 && k < bq.size(); k++) begin
      uv[k] = bq[k].u; lv[k] = bq[k].l;
    end
    chk("t5_user", uv, 8'h01);
    chk("t5_tlast", lv, 8'h00);

    // PKT_BEATS=1 instance: every beat is first and last.
    do_reset();
    fq.push_back(W1);
    wait_beats(4);
    repeat (4) @(posedge clk);
    #1;
    lv = '0; uv = '0;
    for (int k = 0; k < 4 && k < bq.size(); k++) begin
      lv[k] = bq[k].l1; uv[k] = bq[k].u1;
    end
    chk("t6_tlast1", lv, 8'h0F);
    chk("t6_user1", uv, 8'h0F);
    chk("t6_tdata1", tdata1, 0);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
